approx_seq_mult: RTL and testbench
==================================

APPROX_SEQ_MULT -- requirements
Module: approx_seq_mult

Interface
REQ-001 Parameter W, default 8, operand width in bits (2..32).
REQ-002 Parameter APPROX_COLS, default 8, count of low product columns built from approximate adder cells (0..2W).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair a/b/exact_mode valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  unsigned multiplicand.
REQ-008 b  input  W  unsigned multiplier.
REQ-009 exact_mode  input  1  1 = all columns use exact full-adder cells for this operation.
REQ-010 out_valid  output  1  product valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 product  output  2W  result.

Function
REQ-013 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE, in_valid=1: capture a, b, exact_mode; clear acc (2W bits) and step counter i; go to RUN.
REQ-015 RUN, each cycle: acc <= acc + (b[i] ? a<<i : 0) through a 2W-bit ripple adder with carry-in 0; acc is operand X, shifted partial product is operand Y, ripple carry is Z; i increments.
REQ-016 Adder bit j SHALL use the approximate cell when j < APPROX_COLS and captured exact_mode=0, else the exact cell (S = X^Y^Z, Cout = majority).
REQ-017 Approximate cell: S = X | (Y & ~Z); Cout = ~X & Z.
REQ-018 Carry out of bit 2W-1 SHALL be discarded.
REQ-019 After step i=W-1, go to DONE; product = acc; out_valid=1.
REQ-020 Latency: out_valid asserts exactly W+1 cycles after the accepting edge.
REQ-021 DONE: product and out_valid held stable until out_ready=1; on out_valid & out_ready go to IDLE.
REQ-022 Back-to-back: new operands accepted no earlier than the cycle after the DONE handshake (in_ready=1 in that IDLE cycle).
REQ-023 a, b, exact_mode changes during RUN/DONE SHALL have no effect.
REQ-024 APPROX_COLS=0 or exact_mode=1 SHALL yield product = a*b exactly.

Reset
REQ-025 rst_n=0 at a rising edge: state IDLE, acc=0, i=0, product=0, out_valid=0, in_ready=1 on next cycle.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no product emitted.

Configuration
REQ-027 Macro APPROX_SEQ_MULT_ERR_STAT_EN.
REQ-028 Defined: extra outputs err_cnt (16, output, saturating count of completed operations where product != a*b) and err_dist (2W, output, |a*b - product| of the last completed operation); both update on the DONE handshake, reset to 0.
REQ-029 Defined: exact reference product SHALL be computed from the captured operands and not alter product or timing.
REQ-030 Undefined: err_cnt and err_dist ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 W=8, APPROX_COLS=16, a=3, b=3, exact_mode=0 -> product=7, out_valid 9 cycles after accept; with stats err_cnt=1, err_dist=2.
REQ-032 W=8, a=255, b=255, exact_mode=1 -> product=65025; err_cnt unchanged.
REQ-033 W=8, APPROX_COLS=0, a=200, b=13, exact_mode=0 -> product=2600.
REQ-034 Complete op with out_ready=0 for 5 cycles -> product/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n=0 at RUN step 4 -> out_valid never asserts, in_ready=1 after release, next op a=2, b=5, exact_mode=1 -> 10.
REQ-036 a/b toggled every cycle during RUN, captured a=7, b=6, exact_mode=1 -> product=42.

Source files
------------

// File: rtl/approx_seq_mult.sv
// approx_seq_mult: sequential shift-and-add multiplier whose accumulator adder
// uses approximate full-adder cells in the low APPROX_COLS columns, unless the
// captured exact_mode is set.
// Optional error statistics (err_cnt / err_dist) are built when the macro
// APPROX_SEQ_MULT_ERR_STAT_EN is defined.
module approx_seq_mult #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           exact_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
  ,
  output logic [15:0]    err_cnt,
  output logic [2*W-1:0] err_dist
`endif
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg;
  logic            exact_reg;
  logic [PW-1:0]   acc_reg;
  logic [CW-1:0]   i_reg;
  logic [PW-1:0]   product_reg;

  // Step counter reaches W on the extra cycle that publishes the product;
  // this gives W accumulate steps plus one output cycle.
  logic            last_step;
  assign last_step = (i_reg == CW'(W));

  // Partial product for the current step: a shifted by i, gated by b[i].
  logic [W-1:0]    b_sh;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp;
  assign b_sh  = b_reg >> i_reg;
  assign a_ext = {{W{1'b0}}, a_reg};
  assign pp    = b_sh[0] ? (a_ext << i_reg) : '0;

  // Ripple adder: X = accumulator, Y = partial product, Z = ripple carry.
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_col
      localparam bit APPROX_COL = (gi < APPROX_COLS);
      logic x, y, z, use_approx;
      assign x          = acc_reg[gi];
      assign y          = pp[gi];
      assign z          = carry[gi];
      assign use_approx = APPROX_COL && !exact_reg;
      assign sum[gi]    = use_approx ? (x | (y & ~z)) : (x ^ y ^ z);
      // Carry out of the top column is simply not built (discarded).
      if (gi < PW - 1) begin : g_cout
        assign carry[gi+1] = use_approx ? (~x & z)
                                        : ((x & y) | (x & z) | (y & z));
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign product = product_reg;

  // Datapath: operand capture, accumulation steps and product publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      exact_reg   <= 1'b0;
      acc_reg     <= '0;
      i_reg       <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            exact_reg <= exact_mode;
            acc_reg   <= '0;
            i_reg     <= '0;
          end
        end
        RUN: begin
          if (last_step) begin
            product_reg <= acc_reg;
          end else begin
            acc_reg <= sum;
            i_reg   <= i_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
  // Exact reference from the captured operands; observes only.
  logic [PW-1:0] exact_ref;
  assign exact_ref = a_ext * {{W{1'b0}}, b_reg};

  // Error statistics, updated when the result is handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_dist <= '0;
    end else if (state_reg == DONE && out_ready) begin
      if (product_reg != exact_ref && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      err_dist <= (exact_ref >= product_reg) ? (exact_ref - product_reg)
                                             : (product_reg - exact_ref);
    end
  end
`endif

endmodule

// File: tb/tb_approx_seq_mult.sv
// Directed bench for approx_seq_mult: one DUT with all 16 columns approximate,
// one with none approximate. Stats checks are present when
// APPROX_SEQ_MULT_ERR_STAT_EN is defined.
module tb_approx_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        exact_mode = 1'b0;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic        out_ready = 1'b0, out_ready0 = 1'b0;
  logic        in_ready, in_ready0, out_valid, out_valid0;
  logic [15:0] product, product0;
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
  logic [15:0] err_cnt, err_cnt0, err_dist, err_dist0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_seq_mult #(.W(8), .APPROX_COLS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    , .err_cnt(err_cnt), .err_dist(err_dist)
`endif
  );

  approx_seq_mult #(.W(8), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .exact_mode(exact_mode), .out_valid(out_valid0),
    .out_ready(out_ready0), .product(product0)
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    , .err_cnt(err_cnt0), .err_dist(err_dist0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation on DUT sel (0: 16 approx cols, 1: 0 approx cols); optional
  // backpressure of hold cycles before the handshake.
  task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic em, input int hold, input logic [15:0] exp,
                        input string tag);
    int lat;
    a = av; b = bv; exact_mode = em;
    if (sel == 0) in_valid = 1'b1; else in_valid0 = 1'b1;
    tick();
    in_valid = 1'b0; in_valid0 = 1'b0;
    lat = 0;
    while (((sel == 0) ? out_valid : out_valid0) !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_product"}, (sel == 0) ? product : product0, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_product"}, product, exp);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_inready"}, in_ready, 0);
    end
    if (sel == 0) out_ready = 1'b1; else out_ready0 = 1'b1;
    tick();
    out_ready = 1'b0; out_ready0 = 1'b0;
    if (hold > 0) begin
      chk({tag, "_idle_inready"}, in_ready, 1);
      chk({tag, "_idle_valid"}, out_valid, 0);
    end
    $display("op %s a=%0d b=%0d exact=%0d product=%0d latency=%0d",
             tag, av, bv, em, (sel == 0) ? product : product0, lat);
  endtask

  initial begin
    int  lat;
    logic seen;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready0", in_ready0, 1);
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_dist", err_dist, 0);
`endif

    // All-approximate: carries never generate, so product is OR of partials
    run_op(0, 8'd3, 8'd3, 1'b0, 0, 16'd7, "approx_3x3");
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    chk("stat1_cnt", err_cnt, 1);
    chk("stat1_dist", err_dist, 2);
`endif
    run_op(0, 8'd255, 8'd255, 1'b1, 0, 16'd65025, "exact_255x255");
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    chk("stat2_cnt", err_cnt, 1);
    chk("stat2_dist", err_dist, 0);
`endif
    run_op(0, 8'd255, 8'd255, 1'b0, 0, 16'd32767, "approx_255x255");
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    chk("stat3_cnt", err_cnt, 2);
    chk("stat3_dist", err_dist, 32258);
`endif
    run_op(0, 8'd200, 8'd13, 1'b0, 0, 16'd2024, "approx_200x13");
    run_op(1, 8'd200, 8'd13, 1'b0, 0, 16'd2600, "cols0_200x13");

    // Backpressure for 5 cycles
    run_op(0, 8'd7, 8'd9, 1'b1, 5, 16'd63, "hold_7x9");

    // Reset in the middle of RUN aborts the operation
    a = 8'd9; b = 8'd9; exact_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_product", product, 0);
`ifdef APPROX_SEQ_MULT_ERR_STAT_EN
    chk("abort_err_cnt", err_cnt, 0);
`endif
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("abort_no_valid", seen, 0);
    $display("op abort a=9 b=9 reset at step 4 out_valid_seen=%0d", seen);
    run_op(0, 8'd2, 8'd5, 1'b1, 0, 16'd10, "after_abort_2x5");

    // Operand inputs toggling during RUN are ignored
    a = 8'd7; b = 8'd6; exact_mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      a = 8'($urandom);
      b = ~b;
      exact_mode = ~exact_mode;
      tick();
      lat++;
    end
    chk("toggle_latency", lat, 9);
    chk("toggle_product", product, 42);
    $display("op toggle a=7 b=6 exact=1 product=%0d latency=%0d", product, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("toggle_idle", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
